// File: rtl/ride_supervisor.sv
// Ride sequencer: decodes go/stop command bytes, drives pwr_up and qualifies overspeed/battery alarms.
// Optional build macro AUTO_OFF_EN adds an idle timer that powers down an unoccupied ride.
module ride_supervisor #(
  parameter int fast_sim = 1,
  parameter int FAST_CNT = 8,
  parameter int BATT_CNT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_rdy,
  input  logic [7:0] cmd,
  output logic       clr_cmd_rdy,
  input  logic       vld,
  input  logic       rider_off,
  input  logic       too_fast,
  input  logic       batt_low,
  output logic       pwr_up,
  output logic       ovr_spd,
  output logic       batt_warn,
  output logic       lockout
);

  localparam logic [1:0] OFF      = 2'd0;
  localparam logic [1:0] ON       = 2'd1;
  localparam logic [1:0] PEND_OFF = 2'd2;
  localparam logic [1:0] LOCK     = 2'd3;

  localparam int FW = ($clog2(FAST_CNT + 1) < 4) ? 4 : $clog2(FAST_CNT + 1);
  localparam int BW = ($clog2(BATT_CNT + 1) < 4) ? 4 : $clog2(BATT_CNT + 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          cmd_valid;
  logic          go;
  logic          stop;
  logic          idle_expire;
  logic [FW-1:0] fast_cnt;
  logic [BW-1:0] batt_cnt;
  logic          batt_hit;

  // A byte is consumed the cycle after it appears, so the consume cycle must not decode it again.
  assign cmd_valid = cmd_rdy && !clr_cmd_rdy;
  assign go        = cmd_valid && (cmd == 8'h47);
  assign stop      = cmd_valid && (cmd == 8'h53);

`ifdef AUTO_OFF_EN
  localparam int IDLE_W = (fast_sim != 0) ? 15 : 26;

  logic [IDLE_W-1:0] idle_tmr;

  assign idle_expire = (state == ON) && rider_off && (&idle_tmr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_tmr <= '0;
    else if ((state != ON) || !rider_off || (&idle_tmr))
      idle_tmr <= '0;
    else
      idle_tmr <= idle_tmr + 1'b1;
  end
`else
  assign idle_expire = 1'b0;
`endif

  // Commands seen in ON take priority; lockout and idle power-down are re-evaluated next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      OFF: begin
        if (go && !batt_warn)
          state_nxt = ON;
      end
      ON: begin
        if (stop)
          state_nxt = rider_off ? OFF : PEND_OFF;
        else if (!go) begin
          if (batt_warn && rider_off)
            state_nxt = LOCK;
          else if (idle_expire)
            state_nxt = OFF;
        end
      end
      PEND_OFF: begin
        if (go)
          state_nxt = ON;
        else if (rider_off)
          state_nxt = OFF;
      end
      LOCK: begin
        if (go && !batt_warn)
          state_nxt = OFF;
      end
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OFF;
      pwr_up      <= 1'b0;
      lockout     <= 1'b0;
      clr_cmd_rdy <= 1'b0;
    end else begin
      state       <= state_nxt;
      pwr_up      <= (state_nxt == ON) || (state_nxt == PEND_OFF);
      lockout     <= (state_nxt == LOCK);
      clr_cmd_rdy <= cmd_valid;
    end
  end

  // Overspeed qualification; everything is held clear while the controller is unpowered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_cnt <= '0;
      ovr_spd  <= 1'b0;
    end else if (!pwr_up) begin
      fast_cnt <= '0;
      ovr_spd  <= 1'b0;
    end else if (vld) begin
      if (!too_fast) begin
        fast_cnt <= '0;
        ovr_spd  <= 1'b0;
      end else if (fast_cnt < FW'(FAST_CNT)) begin
        fast_cnt <= fast_cnt + 1'b1;
        ovr_spd  <= (fast_cnt >= FW'(FAST_CNT - 1));
      end else begin
        ovr_spd  <= 1'b1;
      end
    end
  end

  // One counter serves both directions: it counts strobes that disagree with the current warning.
  assign batt_hit = batt_warn ? !batt_low : batt_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_cnt  <= '0;
      batt_warn <= 1'b0;
    end else if (vld) begin
      if (!batt_hit) begin
        batt_cnt <= '0;
      end else if (batt_cnt >= BW'(BATT_CNT - 1)) begin
        batt_cnt  <= '0;
        batt_warn <= !batt_warn;
      end else begin
        batt_cnt <= batt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ride_supervisor.sv
// Directed bench for ride_supervisor: expected output vectors go through a scoreboard queue.
// Expected vector order: {pwr_up, clr_cmd_rdy, ovr_spd, batt_warn, lockout}.
module tb_ride_supervisor;

  logic       clk;
  logic       rst_n;
  logic       cmd_rdy;
  logic [7:0] cmd;
  logic       clr_cmd_rdy;
  logic       vld;
  logic       rider_off;
  logic       too_fast;
  logic       batt_low;
  logic       pwr_up;
  logic       ovr_spd;
  logic       batt_warn;
  logic       lockout;

  typedef struct {
    string      tag;
    logic [4:0] value;
  } exp_t;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  localparam logic [7:0] G = 8'h47;
  localparam logic [7:0] S = 8'h53;
  localparam logic [7:0] A = 8'h41;

  ride_supervisor #(.fast_sim(1), .FAST_CNT(8), .BATT_CNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
    .vld(vld), .rider_off(rider_off), .too_fast(too_fast), .batt_low(batt_low),
    .pwr_up(pwr_up), .ovr_spd(ovr_spd), .batt_warn(batt_warn), .lockout(lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic cr, input logic [7:0] c, input logic v,
                               input logic ro, input logic tf, input logic bl);
    cmd_rdy   = cr;
    cmd       = c;
    vld       = v;
    rider_off = ro;
    too_fast  = tf;
    batt_low  = bl;
    @(posedge clk);
    #1;
  endtask

  task automatic expectOutput(input string tag, input logic [4:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [4:0] obs;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end else begin
      e   = sb.pop_front();
      obs = {pwr_up, clr_cmd_rdy, ovr_spd, batt_warn, lockout};
      assert (obs === e.value) else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed %b expected %b", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic stepCheck(input string tag, input logic [4:0] value,
                           input logic cr, input logic [7:0] c, input logic v,
                           input logic ro, input logic tf, input logic bl);
    expectOutput(tag, value);
    applyStimulus(cr, c, v, ro, tf, bl);
    checkOutput();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    cmd_rdy   = 1'b0;
    cmd       = 8'h00;
    vld       = 1'b0;
    rider_off = 1'b0;
    too_fast  = 1'b0;
    batt_low  = 1'b0;
    #23;
    expectOutput("reset_state", 5'b00000);
    checkOutput();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Power up from OFF, then stop under a rider and check the repeated cmd_rdy is ignored.
    stepCheck("go_from_off", 5'b11000, 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("on_idle", 5'b10000, 1'b0, G, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("stop_with_rider", 5'b11000, 1'b1, S, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("consume_cycle_ignored", 5'b10000, 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("pend_off_rider_leaves", 5'b00000, 1'b0, G, 1'b0, 1'b1, 1'b0, 1'b0);

    // Overspeed qualification.
    stepCheck("go_for_speed", 5'b11000, 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      stepCheck($sformatf("fast_strobe_%0d", i), 5'b10000, 1'b0, G, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, G, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    stepCheck("fast_strobe_8", 5'b10100, 1'b0, G, 1'b1, 1'b0, 1'b1, 1'b0);
    stepCheck("ovr_hold_no_vld", 5'b10100, 1'b0, G, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("ovr_clear_strobe", 5'b10000, 1'b0, G, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++)
      applyStimulus(1'b0, G, 1'b1, 1'b0, 1'b1, 1'b0);
    stepCheck("ovr_saturated", 5'b10100, 1'b0, G, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, S, 1'b0, 1'b1, 1'b1, 1'b0);
    stepCheck("ovr_cleared_unpowered", 5'b00000, 1'b0, S, 1'b0, 1'b1, 1'b1, 1'b0);

    // Low battery leads to lockout, then recovery with two go commands.
    stepCheck("go_for_batt", 5'b11000, 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      stepCheck($sformatf("batt_strobe_%0d", i), 5'b10000, 1'b0, G, 1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, G, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    stepCheck("batt_strobe_16", 5'b10010, 1'b0, G, 1'b1, 1'b1, 1'b0, 1'b1);
    stepCheck("enter_lock", 5'b00011, 1'b0, G, 1'b0, 1'b1, 1'b0, 1'b1);
    stepCheck("go_in_lock_batt_low", 5'b01011, 1'b1, G, 1'b0, 1'b1, 1'b0, 1'b1);
    stepCheck("lock_idle", 5'b00011, 1'b0, G, 1'b0, 1'b1, 1'b0, 1'b1);
    stepCheck("other_byte_in_lock", 5'b01011, 1'b1, A, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      stepCheck($sformatf("batt_ok_strobe_%0d", i), 5'b00011, 1'b0, G, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, G, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    stepCheck("batt_ok_strobe_16", 5'b00001, 1'b0, G, 1'b1, 1'b1, 1'b0, 1'b0);
    stepCheck("go_leaves_lock", 5'b01000, 1'b1, G, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("off_after_lock", 5'b00000, 1'b0, G, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("second_go_powers", 5'b11000, 1'b1, G, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("on_after_lock", 5'b10000, 1'b0, G, 1'b0, 1'b1, 1'b0, 1'b0);

    // Unrecognised byte in ON, OFF and PEND_OFF.
    stepCheck("other_byte_on", 5'b11000, 1'b1, A, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("on_still", 5'b10000, 1'b0, A, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("stop_rider_off", 5'b01000, 1'b1, S, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("off_idle", 5'b00000, 1'b0, S, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("other_byte_off", 5'b01000, 1'b1, A, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("stop_in_off_pre", 5'b00000, 1'b0, A, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("stop_in_off", 5'b01000, 1'b1, S, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, S, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("go_for_pend", 5'b11000, 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, G, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("stop_to_pend", 5'b11000, 1'b1, S, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("pend_idle", 5'b10000, 1'b0, S, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("other_byte_pend", 5'b11000, 1'b1, A, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("pend_still", 5'b10000, 1'b0, A, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("pend_rider_off", 5'b00000, 1'b0, A, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while powered.
    stepCheck("go_before_reset", 5'b11000, 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("powered_before_reset", 5'b10000, 1'b0, G, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    expectOutput("async_reset_drop", 5'b00000);
    checkOutput();
    #2;
    rst_n = 1'b1;
    stepCheck("off_after_reset", 5'b00000, 1'b0, G, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef AUTO_OFF_EN
    // Idle timer: a rider glitch mid-count restarts the full interval.
    stepCheck("go_for_idle", 5'b11000, 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20000; i++)
      applyStimulus(1'b0, G, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("idle_glitch", 5'b10000, 1'b0, G, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32699; i++)
      applyStimulus(1'b0, G, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("idle_not_expired", 5'b10000, 1'b0, G, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 199; i++)
      applyStimulus(1'b0, G, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("idle_expired", 5'b00000, 1'b0, G, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
